risc_core8: RTL and testbench
=============================

Name: risc_core8

Overview:
Single-cycle 8-bit RISC processor core with 16-bit instructions, four 8-bit general registers and separate instruction/data memory ports (Harvard). Each clock retires one instruction. Instruction and data memories are external; the core drives addresses and reads or writes data combinationally. It is the CPU block of the risc_processor subsystem.

Parameters:
- None. Widths are fixed: PC/address 8, data 8, instruction 16, registers 4.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- instr_addr  out  8  PC; instruction fetch address
- instr_data  in  16  instruction at instr_addr, valid in the same cycle
- data_addr  out  8  data memory address (base + imm)
- data_write  out  1  data memory write strobe; high only for SW
- data_out  out  8  store data (register rt)
- data_in  in  8  load data, valid combinationally in the same cycle

Behaviour:
- State: pc[7:0] and register_file[0:3] (8-bit each). The array is named register_file and sits in the core top level for hierarchical probing.
- Reset (sync, active high):
  - pc <= 0; all register_file entries <= 0.
  - data_write is forced 0 while reset=1.
- Instruction fields:
  - op = [15:12]
  - I-type: rs(base) = [11:10], rt = [9:8], imm = [7:0]
  - R-type (op 0000): rs = [7:6], rt = [5:4], rd = [3:2], funct = [1:0]
- Opcodes:
  - 0000 R-type, by funct: 00 ADD, 01 SUB, 10 AND, 11 OR. rd <= rs op rt.
  - 0001 ADDI: rt <= rs + imm.
  - 0010 LW: rt <= data_in; data_addr = rs + imm.
  - 0011 SW: data_addr = rs + imm, data_out = rt, data_write = 1.
  - 0100 BEQ: if rs == rt, pc <= pc + 1 + sext(imm).
  - 0101 JMP: pc <= imm.
  - 0110–1111: NOP.
- R0 reads as 0 regardless of contents. Writes to R0 are discarded.
- All arithmetic is 8-bit modulo 256. No flags, no carry, no overflow trap.
- PC:
  - Default next PC is pc + 1, wrapping 0xFF -> 0x00.
  - Branch target also wraps mod 256.
- Combinational outputs:
  - data_addr and data_out are driven combinationally for every instruction; they are don't-care unless LW/SW.
  - data_write is combinational: (op == 0011) and not reset.
- Latency: every instruction completes in one cycle. The result is visible in register_file after the rising edge that ends the instruction's cycle.
- Read-during-write: a source register reads the pre-edge value. No forwarding is needed in a single-cycle design.
- Reset asserted mid-program: the next edge clears pc and registers; the current instruction's write is discarded.
- LW with rt = R0 has no effect. SW drives the R0 value 0 when rt = R0.

Decomposition:
- Package risc_core_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP)
  - funct localparams (F_ADD, F_SUB, F_AND, F_OR)
  - field bit-position constants
- One sub-module, risc_alu: inputs a[7:0], b[7:0], op[1:0]; output y[7:0]; combinational.
- Register file, PC and decode stay in risc_core8.

Test Plan:
- Reset held 3 cycles -> instr_addr=0x00, register_file all 0, data_write=0. After release, PC increments by 1 per cycle.
- Load and add:
  - LW R1,8(R0) (0x2108) with data_in=0x0A -> data_addr=0x08, R1=0x0A.
  - LW R2,9(R0) (0x2209) with data_in=0x01 -> data_addr=0x09, R2=0x01.
  - ADD R3,R1,R2 (0x006C) -> R3=0x0B.
- Store: SW R3,10(R0) (0x330A) -> same cycle data_addr=0x0A, data_out=0x0B, data_write=1. data_write returns to 0 on the next instruction.
- ALU and wrap:
  - ADDI R1,R0,0xFF, then ADD R2,R1,R1 -> R2=0xFE.
  - SUB of 0x01-0x02 -> 0xFF.
  - AND/OR of 0xF0/0x3C -> 0x30/0xFC.
  - ADDI R0,R0,5 -> R0 still reads 0.
- Control flow:
  - BEQ R0,R0,imm=0xFE at pc=0x10 -> next pc=0x0F.
  - BEQ with unequal operands -> pc+1.
  - JMP 0x40 -> pc=0x40.
  - NOP at pc=0xFF -> pc=0x00.
- Reset mid-run: assert reset during an LW -> target register stays 0, pc=0 on the next edge, data_write=0 throughout.

Source files
------------

// File: rtl/risc_core_pkg.sv
// Shared constants for the risc_core8 single-cycle CPU: widths, opcodes,
// ALU function codes and instruction field bit positions.
package risc_core_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned REG_IDX_W = 2;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;

  localparam logic [1:0] F_ADD = 2'd0;
  localparam logic [1:0] F_SUB = 2'd1;
  localparam logic [1:0] F_AND = 2'd2;
  localparam logic [1:0] F_OR  = 2'd3;

  // I-type fields
  localparam int unsigned OP_HI   = 15;
  localparam int unsigned OP_LO   = 12;
  localparam int unsigned RS_I_HI = 11;
  localparam int unsigned RS_I_LO = 10;
  localparam int unsigned RT_I_HI = 9;
  localparam int unsigned RT_I_LO = 8;
  localparam int unsigned IMM_HI  = 7;
  localparam int unsigned IMM_LO  = 0;

  // R-type fields
  localparam int unsigned RS_R_HI = 7;
  localparam int unsigned RS_R_LO = 6;
  localparam int unsigned RT_R_HI = 5;
  localparam int unsigned RT_R_LO = 4;
  localparam int unsigned RD_R_HI = 3;
  localparam int unsigned RD_R_LO = 2;
  localparam int unsigned FN_HI   = 1;
  localparam int unsigned FN_LO   = 0;

endpackage

// File: rtl/risc_alu.sv
// Combinational 8-bit ALU: add, subtract, and, or (all modulo 256).
module risc_alu
  import risc_core_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] op,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    case (op)
      F_ADD:   y = a + b;
      F_SUB:   y = a - b;
      F_AND:   y = a & b;
      F_OR:    y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/risc_core8.sv
// Single-cycle 8-bit Harvard RISC core: one instruction retires per clock,
// register file and PC live here so they can be probed hierarchically.
module risc_core8
  import risc_core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  instr_addr,
  input  logic [15:0] instr_data,
  output logic [7:0]  data_addr,
  output logic        data_write,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in
);

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] register_file [NUM_REGS];

  logic [3:0]           op;
  logic [REG_IDX_W-1:0] rs_i, rt_i, rs_r, rt_r, rd_r;
  logic [1:0]           funct;
  logic [DATA_W-1:0]    imm;

  assign op    = instr_data[OP_HI:OP_LO];
  assign rs_i  = instr_data[RS_I_HI:RS_I_LO];
  assign rt_i  = instr_data[RT_I_HI:RT_I_LO];
  assign imm   = instr_data[IMM_HI:IMM_LO];
  assign rs_r  = instr_data[RS_R_HI:RS_R_LO];
  assign rt_r  = instr_data[RT_R_HI:RT_R_LO];
  assign rd_r  = instr_data[RD_R_HI:RD_R_LO];
  assign funct = instr_data[FN_HI:FN_LO];

  // R0 is hard-wired to zero on every read port
  logic [DATA_W-1:0] rs_i_val, rt_i_val, rs_r_val, rt_r_val;
  assign rs_i_val = (rs_i == '0) ? '0 : register_file[rs_i];
  assign rt_i_val = (rt_i == '0) ? '0 : register_file[rt_i];
  assign rs_r_val = (rs_r == '0) ? '0 : register_file[rs_r];
  assign rt_r_val = (rt_r == '0) ? '0 : register_file[rt_r];

  // One ALU serves R-type ops and the base+imm sum for ADDI/LW/SW
  logic              is_rtype;
  logic [DATA_W-1:0] alu_a, alu_b, alu_y;
  logic [1:0]        alu_op;

  assign is_rtype = (op == OP_RTYPE);
  assign alu_a    = is_rtype ? rs_r_val : rs_i_val;
  assign alu_b    = is_rtype ? rt_r_val : imm;
  assign alu_op   = is_rtype ? funct : F_ADD;

  risc_alu u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  assign instr_addr = pc;
  assign data_addr  = alu_y;
  assign data_out   = rt_i_val;
  assign data_write = (op == OP_SW) && !reset;

  logic [ADDR_W-1:0]    pc_next;
  logic                 wr_en;
  logic [REG_IDX_W-1:0] wr_idx;
  logic [DATA_W-1:0]    wr_data;

  // Decode: next PC and register write-back
  always_comb begin
    pc_next = pc + ADDR_W'(1);
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    case (op)
      OP_RTYPE: begin
        wr_en   = 1'b1;
        wr_idx  = rd_r;
        wr_data = alu_y;
      end
      OP_ADDI: begin
        wr_en   = 1'b1;
        wr_idx  = rt_i;
        wr_data = alu_y;
      end
      OP_LW: begin
        wr_en   = 1'b1;
        wr_idx  = rt_i;
        wr_data = data_in;
      end
      // Adding the 8-bit imm modulo 256 equals adding its sign extension
      OP_BEQ: if (rs_i_val == rt_i_val) pc_next = pc + ADDR_W'(1) + imm;
      OP_JMP: pc_next = imm;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      for (int i = 0; i < NUM_REGS; i++) register_file[i] <= '0;
    end else begin
      pc <= pc_next;
      if (wr_en && (wr_idx != '0)) register_file[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_risc_core8.sv
// Self-checking bench for risc_core8: directed program fragments plus random
// instruction streams against an instruction-level reference model.
module tb_risc_core8;

  logic        clk;
  logic        reset;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic [7:0]  data_addr;
  logic        data_write;
  logic [7:0]  data_out;
  logic [7:0]  data_in;

  risc_core8 dut (
    .clk        (clk),
    .reset      (reset),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .data_addr  (data_addr),
    .data_write (data_write),
    .data_out   (data_out),
    .data_in    (data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Architectural reference state
  int m_pc;
  int m_reg [4];

  // Expectations for the step just executed, and what the DUT showed
  int   exp_pc, exp_daddr, exp_dout;
  logic exp_dwr;
  int   exp_op;
  logic [7:0] obs_pc, obs_daddr, obs_dout;
  logic       obs_dwr;

  function automatic int rval(int idx);
    return (idx == 0) ? 0 : m_reg[idx];
  endfunction

  function automatic void model_reset();
    m_pc = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
  endfunction

  // Executes one instruction on the model, recording pre-edge expectations
  function automatic void model_exec(int ins, int din);
    int op, rs, rt, imm, a, b, fn, dst, val, simm;
    bit wr;
    op  = ins / 4096;
    rs  = (ins / 1024) % 4;
    rt  = (ins / 256) % 4;
    imm = ins % 256;
    exp_op    = op;
    exp_pc    = m_pc;
    exp_daddr = (rval(rs) + imm) % 256;
    exp_dout  = rval(rt);
    exp_dwr   = (op == 3);
    wr  = 0;
    dst = 0;
    val = 0;
    m_pc = (m_pc + 1) % 256;
    if (op == 0) begin
      a   = rval((imm / 64) % 4);
      b   = rval((imm / 16) % 4);
      dst = (imm / 4) % 4;
      fn  = imm % 4;
      if (fn == 0) val = (a + b) % 256;
      else if (fn == 1) val = (a - b + 256) % 256;
      else if (fn == 2) val = a & b;
      else val = a | b;
      wr = 1;
    end else if (op == 1) begin
      dst = rt; val = (rval(rs) + imm) % 256; wr = 1;
    end else if (op == 2) begin
      dst = rt; val = din % 256; wr = 1;
    end else if (op == 4) begin
      simm = (imm >= 128) ? imm - 256 : imm;
      if (rval(rs) == rval(rt)) m_pc = (exp_pc + 1 + simm + 256) % 256;
    end else if (op == 5) begin
      m_pc = imm;
    end
    if (wr && dst != 0) m_reg[dst] = val;
  endfunction

  // Apply one instruction for one cycle; capture combinational outputs first
  task automatic step(input logic [15:0] ins, input logic [7:0] din);
    @(negedge clk);
    instr_data = ins;
    data_in    = din;
    #1;
    obs_pc    = instr_addr;
    obs_daddr = data_addr;
    obs_dout  = data_out;
    obs_dwr   = data_write;
    model_exec(int'(ins), int'(din));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    instr_data = 16'h3F00;
    data_in    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if (instr_addr !== 8'h00) begin
      n_fail++; $display("FAIL reset_pc: got %h want 00", instr_addr);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dut.register_file[i] !== 8'h00) begin
        n_fail++; $display("FAIL reset_reg%0d: got %h want 00", i, dut.register_file[i]);
      end
    end
    n_cmp++;
    if (data_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_dwr: got %b want 0 (SW under reset)", data_write);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(16'h7000, 8'h00);
      n_cmp++;
      if (obs_pc !== 8'(i)) begin
        n_fail++; $display("FAIL reset_incr%0d: got %h want %h", i, obs_pc, 8'(i));
      end
    end
    n_cmp++;
    if (instr_addr !== 8'h03) begin
      n_fail++; $display("FAIL reset_incr_end: got %h want 03", instr_addr);
    end
  endtask

  task automatic test_load_add();
    step(16'h2108, 8'h0A);
    n_cmp++;
    if (obs_daddr !== 8'h08 || dut.register_file[1] !== 8'h0A) begin
      n_fail++; $display("FAIL lw_r1: addr %h R1 %h want 08 0a", obs_daddr, dut.register_file[1]);
    end
    step(16'h2209, 8'h01);
    n_cmp++;
    if (obs_daddr !== 8'h09 || dut.register_file[2] !== 8'h01) begin
      n_fail++; $display("FAIL lw_r2: addr %h R2 %h want 09 01", obs_daddr, dut.register_file[2]);
    end
    step(16'h006C, 8'h55);
    n_cmp++;
    if (dut.register_file[3] !== 8'h0B) begin
      n_fail++; $display("FAIL add_r3: got %h want 0b", dut.register_file[3]);
    end
  endtask

  task automatic test_store();
    step(16'h330A, 8'($urandom));
    n_cmp++;
    if (obs_daddr !== 8'h0A || obs_dout !== 8'h0B || obs_dwr !== 1'b1) begin
      n_fail++; $display("FAIL sw: addr %h data %h wr %b want 0a 0b 1", obs_daddr, obs_dout, obs_dwr);
    end
    step(16'h7000, 8'h00);
    n_cmp++;
    if (obs_dwr !== 1'b0) begin
      n_fail++; $display("FAIL sw_release: wr %b want 0", obs_dwr);
    end
    // SW with rt = R0 must present zero
    step(16'h3004, 8'h00);
    n_cmp++;
    if (obs_dout !== 8'h00 || obs_daddr !== 8'h04) begin
      n_fail++; $display("FAIL sw_r0: data %h addr %h want 00 04", obs_dout, obs_daddr);
    end
  endtask

  task automatic test_alu_wrap();
    step(16'h11FF, 8'h00);
    step(16'h0058, 8'h00);
    n_cmp++;
    if (dut.register_file[2] !== 8'hFE) begin
      n_fail++; $display("FAIL add_wrap: got %h want fe", dut.register_file[2]);
    end
    step(16'h1101, 8'h00);
    step(16'h1202, 8'h00);
    step(16'h006D, 8'h00);
    n_cmp++;
    if (dut.register_file[3] !== 8'hFF) begin
      n_fail++; $display("FAIL sub_wrap: got %h want ff", dut.register_file[3]);
    end
    step(16'h11F0, 8'h00);
    step(16'h123C, 8'h00);
    step(16'h006E, 8'h00);
    n_cmp++;
    if (dut.register_file[3] !== 8'h30) begin
      n_fail++; $display("FAIL and: got %h want 30", dut.register_file[3]);
    end
    step(16'h006F, 8'h00);
    n_cmp++;
    if (dut.register_file[3] !== 8'hFC) begin
      n_fail++; $display("FAIL or: got %h want fc", dut.register_file[3]);
    end
    step(16'h1005, 8'h00);
    step(16'h000C, 8'h00);
    n_cmp++;
    if (dut.register_file[3] !== 8'h00) begin
      n_fail++; $display("FAIL r0_zero: R0+R0 got %h want 00", dut.register_file[3]);
    end
    // LW into R0 is discarded
    step(16'h2000, 8'hA5);
    step(16'h000C, 8'h00);
    n_cmp++;
    if (dut.register_file[3] !== 8'h00) begin
      n_fail++; $display("FAIL lw_r0: got %h want 00", dut.register_file[3]);
    end
  endtask

  task automatic test_control();
    step(16'h5010, 8'h00);
    n_cmp++;
    if (instr_addr !== 8'h10) begin
      n_fail++; $display("FAIL jmp10: got %h want 10", instr_addr);
    end
    step(16'h40FE, 8'h00);
    n_cmp++;
    if (instr_addr !== 8'h0F) begin
      n_fail++; $display("FAIL beq_back: got %h want 0f", instr_addr);
    end
    step(16'h1105, 8'h00);
    step(16'h4120, 8'h00);
    n_cmp++;
    if (instr_addr !== 8'h11) begin
      n_fail++; $display("FAIL beq_ne: got %h want 11", instr_addr);
    end
    step(16'h5040, 8'h00);
    n_cmp++;
    if (instr_addr !== 8'h40) begin
      n_fail++; $display("FAIL jmp40: got %h want 40", instr_addr);
    end
    step(16'h50FF, 8'h00);
    step(16'hF123, 8'h00);
    n_cmp++;
    if (instr_addr !== 8'h00) begin
      n_fail++; $display("FAIL pc_wrap: got %h want 00", instr_addr);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    for (int n = 0; n < 400; n++) begin
      ins = 16'($urandom);
      // Bias toward defined opcodes so most cycles do real work
      if (($urandom % 4) != 0) ins[15:12] = 4'($urandom % 6);
      step(ins, 8'($urandom));
      n_cmp++;
      if (obs_pc !== 8'(exp_pc) || obs_dwr !== exp_dwr) begin
        n_fail++; $display("FAIL rand_pc_wr[%0d] ins %h: pc %h wr %b want %h %b",
                           n, ins, obs_pc, obs_dwr, 8'(exp_pc), exp_dwr);
      end
      if (exp_op == 2 || exp_op == 3) begin
        n_cmp++;
        if (obs_daddr !== 8'(exp_daddr) || (exp_op == 3 && obs_dout !== 8'(exp_dout))) begin
          n_fail++; $display("FAIL rand_mem[%0d] ins %h: addr %h data %h want %h %h",
                             n, ins, obs_daddr, obs_dout, 8'(exp_daddr), 8'(exp_dout));
        end
      end
      for (int i = 1; i < 4; i++) begin
        n_cmp++;
        if (dut.register_file[i] !== 8'(m_reg[i])) begin
          n_fail++; $display("FAIL rand_reg[%0d] R%0d: got %h want %h",
                             n, i, dut.register_file[i], 8'(m_reg[i]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(16'h1177, 8'h00);
    step(16'h5033, 8'h00);
    @(negedge clk);
    reset      = 1'b1;
    instr_data = 16'h2205;
    data_in    = 8'h77;
    #1;
    n_cmp++;
    if (data_write !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_dwr_lw: got %b want 0", data_write);
    end
    @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if (instr_addr !== 8'h00 || dut.register_file[2] !== 8'h00 || dut.register_file[1] !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_state: pc %h R1 %h R2 %h want 00 00 00",
                         instr_addr, dut.register_file[1], dut.register_file[2]);
    end
    @(negedge clk);
    instr_data = 16'h3F00;
    #1;
    n_cmp++;
    if (data_write !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_dwr_sw: got %b want 0", data_write);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(16'h2205, 8'h5A);
    n_cmp++;
    if (obs_pc !== 8'h00 || dut.register_file[2] !== 8'h5A) begin
      n_fail++; $display("FAIL post_reset_lw: pc %h R2 %h want 00 5a", obs_pc, dut.register_file[2]);
    end
  endtask

  initial begin
    reset      = 1'b1;
    instr_data = 16'h0000;
    data_in    = 8'h00;
    test_reset();
    test_load_add();
    test_store();
    test_alu_wrap();
    test_control();
    test_random();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
